// File: rtl/multi_sing_float.sv
// IEEE-754 binary32 multiplier: two-stage pipeline (unpack/multiply, then normalize/round).
// Round to nearest even, subnormal inputs and outputs flushed to signed zero.
module multi_sing_float (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    output logic [31:0] result
);

    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    logic signed [9:0] exp_sum;

    logic [47:0]       s1_prod;
    logic signed [9:0] s1_exp;
    logic              s1_sign;
    logic              s1_nan;
    logic              s1_inf;
    logic              s1_zero;

    always_comb begin
        ea      = num1[30:23];
        eb      = num2[30:23];
        fa      = num1[22:0];
        fb      = num2[22:0];
        a_zero  = (ea == '0);
        b_zero  = (eb == '0);
        a_inf   = (ea == '1) && (fa == '0);
        b_inf   = (eb == '1) && (fb == '0);
        a_nan   = (ea == '1) && (fa != '0);
        b_nan   = (eb == '1) && (fb != '0);
        exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_prod <= '0;
            s1_exp  <= '0;
            s1_sign <= 1'b0;
            s1_nan  <= 1'b0;
            s1_inf  <= 1'b0;
            s1_zero <= 1'b0;
        end else begin
            s1_prod <= {1'b1, fa} * {1'b1, fb};
            s1_exp  <= exp_sum;
            s1_sign <= num1[31] ^ num2[31];
            s1_nan  <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
            s1_inf  <= a_inf | b_inf;
            s1_zero <= a_zero | b_zero;
        end
    end

    logic [23:0]       mant;
    logic              guard, rbit, sticky, rnd_up;
    logic [24:0]       mant_r;
    logic [22:0]       frac;
    logic signed [9:0] exp_n, exp_r;
    logic [31:0]       res_d;

    always_comb begin
        if (s1_prod[47]) begin
            mant   = s1_prod[47:24];
            guard  = s1_prod[23];
            rbit   = s1_prod[22];
            sticky = |s1_prod[21:0];
            exp_n  = s1_exp + 10'sd1;
        end else begin
            mant   = s1_prod[46:23];
            guard  = s1_prod[22];
            rbit   = s1_prod[21];
            sticky = |s1_prod[20:0];
            exp_n  = s1_exp;
        end

        rnd_up = guard & (rbit | sticky | mant[0]);
        mant_r = {1'b0, mant} + {24'd0, rnd_up};

        // A carry out of rounding leaves mantissa 1.0, so the fraction collapses to zero
        if (mant_r[24]) begin
            frac  = mant_r[23:1];
            exp_r = exp_n + 10'sd1;
        end else begin
            frac  = mant_r[22:0];
            exp_r = exp_n;
        end

        if (s1_nan)
            res_d = 32'h7FC0_0000;
        else if (s1_inf)
            res_d = {s1_sign, 8'hFF, 23'h0};
        else if (s1_zero)
            res_d = {s1_sign, 31'h0};
        else if (exp_r >= 10'sd255)
            res_d = {s1_sign, 8'hFF, 23'h0};
        else if (exp_r <= 10'sd0)
            res_d = {s1_sign, 31'h0};
        else
            res_d = {s1_sign, exp_r[7:0], frac};
    end

    always_ff @(posedge clk) begin
        if (reset)
            result <= '0;
        else
            result <= res_d;
    end

endmodule

// File: tb/tb_multi_sing_float.sv
// Bench for multi_sing_float: directed vectors with fixed expectations plus random
// operands checked against an integer-arithmetic reference of binary32 RNE/FTZ multiply.
module tb_multi_sing_float;

    logic        clk;
    logic        reset;
    logic [31:0] num1;
    logic [31:0] num2;
    logic [31:0] result;

    int unsigned n_cmp;
    int unsigned n_bad;

    logic [31:0] exp1;
    logic [31:0] exp2;

    multi_sing_float dut (
        .clk    (clk),
        .reset  (reset),
        .num1   (num1),
        .num2   (num2),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    // Exact product as an integer, then round by comparing the discarded remainder to one half.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e, msb, k;
        longint unsigned ma, mb, p, q, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0))
            return 32'h7FC0_0000;
        if ((ea == 255 && eb == 0) || (ea == 0 && eb == 255))
            return 32'h7FC0_0000;
        if (ea == 255 || eb == 255)
            return {s, 8'hFF, 23'h0};
        if (ea == 0 || eb == 0)
            return {s, 31'h0};
        ma = 64'h80_0000 + 64'(a[22:0]);
        mb = 64'h80_0000 + 64'(b[22:0]);
        p  = ma * mb;
        msb  = (p >= (64'd1 << 47)) ? 47 : 46;
        k    = msb - 23;
        q    = p >> k;
        rem  = p - (q << k);
        half = 64'd1 << (k - 1);
        if (rem > half || (rem == half && q[0]))
            q = q + 1;
        if (q == (64'd1 << 24)) begin
            q   = 64'd1 << 23;
            msb = msb + 1;
        end
        e = ea + eb - 127 + (msb - 46);
        if (e >= 255)
            return {s, 8'hFF, 23'h0};
        if (e <= 0)
            return {s, 31'h0};
        return {s, 8'(e), q[22:0]};
    endfunction

    // One clock: present operands, track the 2-deep expectation pipeline, check at negedge.
    task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input string tag);
        reset = rst;
        num1  = a;
        num2  = b;
        @(posedge clk);
        if (rst) begin
            exp2 = 32'h0;
            exp1 = 32'h0;
        end else begin
            exp2 = exp1;
            exp1 = want;
        end
        @(negedge clk);
        check_eq(tag, result, exp2);
    endtask

    function automatic logic [31:0] rnd_normal();
        logic [7:0] e;
        e = 8'($urandom_range(254, 1));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    function automatic logic [31:0] rnd_edge_exp();
        logic [7:0] e;
        e = ($urandom_range(1, 0) != 0) ? 8'($urandom_range(254, 190))
                                         : 8'($urandom_range(64, 1));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    logic [31:0] dv_a [12];
    logic [31:0] dv_b [12];
    logic [31:0] dv_r [12];

    initial begin
        logic [31:0] a, b;
        n_cmp = 0;
        n_bad = 0;
        exp1  = 32'h0;
        exp2  = 32'h0;

        dv_a = '{32'h4020_0000, 32'h3F80_0000, 32'h3FC0_0000, 32'h7F00_0000,
                 32'h0080_0000, 32'h7F80_0000, 32'h7FC0_0001, 32'h3F80_0001,
                 32'hFF80_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0001};
        dv_b = '{32'h3FA0_0000, 32'hBF80_0000, 32'h3FC0_0000, 32'h4000_0000,
                 32'h0080_0000, 32'h0000_0000, 32'h4040_0000, 32'h3F80_0001,
                 32'h4000_0000, 32'h4040_0000, 32'hFF80_0001, 32'h4040_0000};
        dv_r = '{32'h4048_0000, 32'hBF80_0000, 32'h4010_0000, 32'h7F80_0000,
                 32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h3F80_0002,
                 32'hFF80_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h0000_0000};

        step(1'b1, 32'h0, 32'h0, 32'h0, "reset");
        step(1'b1, 32'h0, 32'h0, 32'h0, "reset");

        // Directed pairs back to back, each emerging two edges after it is sampled
        for (int i = 0; i < 12; i++)
            step(1'b0, dv_a[i], dv_b[i], dv_r[i], $sformatf("directed%0d", i));
        step(1'b0, 32'h0, 32'h0, 32'h0, "drain");
        step(1'b0, 32'h0, 32'h0, 32'h0, "drain");

        for (int i = 0; i < 300; i++) begin
            a = rnd_normal();
            b = rnd_normal();
            step(1'b0, a, b, ref_mul(a, b), "rand_normal");
        end

        // Mid-stream reset: in-flight products vanish, then zeros until fresh data arrives
        step(1'b0, 32'h4020_0000, 32'h3FA0_0000, 32'h4048_0000, "pre_reset");
        step(1'b0, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, "pre_reset");
        step(1'b1, 32'h4000_0000, 32'h4000_0000, 32'h0, "mid_reset");
        step(1'b0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, "post_reset");
        step(1'b0, 32'h3F80_0000, 32'h4040_0000, 32'h4040_0000, "post_reset");
        step(1'b0, 32'h0, 32'h0, 32'h0, "post_reset");

        for (int i = 0; i < 200; i++) begin
            a = rnd_edge_exp();
            b = rnd_edge_exp();
            step(1'b0, a, b, ref_mul(a, b), "rand_range");
        end

        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 8 == 0) a = {a[31], 8'hFF, (i % 16 == 0) ? 23'h0 : a[22:0]};
            if (i % 8 == 4) b = {b[31], 8'h00, b[22:0]};
            step(1'b0, a, b, ref_mul(a, b), "rand_any");
        end
        step(1'b0, 32'h0, 32'h0, 32'h0, "drain");
        step(1'b0, 32'h0, 32'h0, 32'h0, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
